pc_sequencer: RTL

//   Sequences the 64-bit program counter by driving its 2-bit PS select and 64-bit target input each cycle.

---
 rtl/pc_pkg.sv | 28 ++
 rtl/pc_redirect_latch.sv | 56 +++++
 rtl/pc_sequencer.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer: PS select codes,
// sequencer state encoding and the kind of a held redirect.
package pc_pkg;

  localparam logic [1:0] PS_HOLD   = 2'b00;
  localparam logic [1:0] PS_INC    = 2'b01;
  localparam logic [1:0] PS_BRANCH = 2'b10;
  localparam logic [1:0] PS_ABS    = 2'b11;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2,
    ST_HALT  = 2'd3
  } pc_state_e;

  // Ordered so that a larger value is a higher-priority redirect.
  typedef enum logic {
    RK_BRANCH = 1'b0,
    RK_JUMP   = 1'b1
  } redir_kind_e;

  // PS code that replays a held redirect of the given kind.
  function automatic logic [1:0] kind_to_ps(input redir_kind_e kind);
    return (kind == RK_JUMP) ? PS_ABS : PS_BRANCH;
  endfunction

endpackage

// File: rtl/pc_redirect_latch.sv
// Holds one redirect (kind + address) that arrived while the PC was frozen.
// A new redirect replaces the held one only when it is of equal or higher
// priority; a simultaneous clear and set loads the new redirect.
module pc_redirect_latch
  import pc_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             set,
  input  redir_kind_e      set_kind,
  input  logic [WIDTH-1:0] set_addr,
  output logic             pend_valid,
  output redir_kind_e      pend_kind,
  output logic [WIDTH-1:0] pend_addr
);

  logic             valid_q, valid_d;
  redir_kind_e      kind_q, kind_d;
  logic [WIDTH-1:0] addr_q, addr_d;

  // Next pending value: clear first, then priority-checked load.
  always_comb begin
    valid_d = valid_q;
    kind_d  = kind_q;
    addr_d  = addr_q;
    if (clear) begin
      valid_d = 1'b0;
    end
    if (set && (clear || !valid_q || (set_kind >= kind_q))) begin
      valid_d = 1'b1;
      kind_d  = set_kind;
      addr_d  = set_addr;
    end
  end

  // Pending register, emptied by asynchronous reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      kind_q  <= RK_BRANCH;
      addr_q  <= '0;
    end else begin
      valid_q <= valid_d;
      kind_q  <= kind_d;
      addr_q  <= addr_d;
    end
  end

  assign pend_valid = valid_q;
  assign pend_kind  = kind_q;
  assign pend_addr  = addr_q;

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: merges stall/branch/jump/halt requests into one
// registered PS command plus target for the PC. Redirects seen during a stall
// are held until release. Optional exception entry is compiled in with the
// PCSEQ_EXC_EN macro (adds exc_req / exc_vector).
//
// Handshake: there is no valid/ready pairing; each request input is sampled
// at every rising edge and its effect appears on ps/pc_target right after
// that edge, so the PC moves at the following edge.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int WIDTH       = 64,
  parameter int BOOT_CYCLES = 4
) (
  input  logic             clock,
  input  logic             reset,
`ifdef PCSEQ_EXC_EN
  input  logic             exc_req,
  input  logic [WIDTH-1:0] exc_vector,
`endif
  input  logic             stall,
  input  logic             halt,
  input  logic             br_req,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  input  logic             jr_req,
  input  logic [WIDTH-1:0] jr_addr,
  output logic [1:0]       ps,
  output logic [WIDTH-1:0] pc_target,
  output logic             redirect,
  output logic             halted,
  output pc_state_e        state_dbg
);

  localparam logic [7:0] BOOT_LAST = 8'(BOOT_CYCLES - 1);

  pc_state_e        state_q, state_d;
  logic [7:0]       boot_cnt_q, boot_cnt_d;
  logic [1:0]       ps_q, ps_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic             redirect_q, redirect_d;
  logic             halted_q, halted_d;

  logic             exc_hit;
  logic [WIDTH-1:0] exc_addr;
  logic             br_hit;

  logic             pend_clr, pend_set;
  redir_kind_e      pend_set_kind;
  logic [WIDTH-1:0] pend_set_addr;
  logic             pend_valid;
  redir_kind_e      pend_kind;
  logic [WIDTH-1:0] pend_addr;

`ifdef PCSEQ_EXC_EN
  assign exc_hit  = exc_req;
  assign exc_addr = exc_vector;
`else
  assign exc_hit  = 1'b0;
  assign exc_addr = '0;
`endif

  assign br_hit = br_req & br_taken;

  pc_redirect_latch #(.WIDTH(WIDTH)) u_pending (
    .clock      (clock),
    .reset      (reset),
    .clear      (pend_clr),
    .set        (pend_set),
    .set_kind   (pend_set_kind),
    .set_addr   (pend_set_addr),
    .pend_valid (pend_valid),
    .pend_kind  (pend_kind),
    .pend_addr  (pend_addr)
  );

  // Next state and next registered outputs; PS defaults to hold, target holds.
  always_comb begin
    state_d       = state_q;
    boot_cnt_d    = boot_cnt_q;
    ps_d          = PS_HOLD;
    tgt_d         = tgt_q;
    halted_d      = 1'b0;
    pend_clr      = 1'b0;
    pend_set      = 1'b0;
    pend_set_kind = RK_BRANCH;
    pend_set_addr = br_target;

    case (state_q)
      ST_BOOT: begin
        boot_cnt_d = boot_cnt_q + 8'd1;
        if (boot_cnt_q == BOOT_LAST) state_d = ST_RUN;
      end

      ST_RUN, ST_STALL: begin
        if (halt) begin
          // Halt beats everything, including a held redirect.
          state_d  = ST_HALT;
          halted_d = 1'b1;
          pend_clr = 1'b1;
        end else if (exc_hit) begin
          // Exception entry overrides the stall and drops any held redirect.
          state_d  = ST_RUN;
          ps_d     = PS_ABS;
          tgt_d    = exc_addr;
          pend_clr = 1'b1;
        end else if (stall) begin
          state_d = ST_STALL;
          if (jr_req) begin
            pend_set      = 1'b1;
            pend_set_kind = RK_JUMP;
            pend_set_addr = jr_addr;
          end else if (br_hit) begin
            pend_set      = 1'b1;
            pend_set_kind = RK_BRANCH;
            pend_set_addr = br_target;
          end
        end else begin
          // Fresh requests win over (and discard) a held redirect.
          state_d  = ST_RUN;
          pend_clr = 1'b1;
          if (jr_req) begin
            ps_d  = PS_ABS;
            tgt_d = jr_addr;
          end else if (br_hit) begin
            ps_d  = PS_BRANCH;
            tgt_d = br_target;
          end else if (pend_valid && (state_q == ST_STALL)) begin
            ps_d  = kind_to_ps(pend_kind);
            tgt_d = pend_addr;
          end else begin
            ps_d  = PS_INC;
          end
        end
      end

      ST_HALT: begin
        halted_d = 1'b1;
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase

    redirect_d = ps_d[1];
  end

  // State, boot counter and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_BOOT;
      boot_cnt_q <= 8'd0;
      ps_q       <= PS_HOLD;
      tgt_q      <= '0;
      redirect_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
      ps_q       <= ps_d;
      tgt_q      <= tgt_d;
      redirect_q <= redirect_d;
      halted_q   <= halted_d;
    end
  end

  assign ps        = ps_q;
  assign pc_target = tgt_q;
  assign redirect  = redirect_q;
  assign halted    = halted_q;
  assign state_dbg = state_q;

endmodule
